fifo_uart_tx: RTL and testbench

- Downstream drain stage for the synchronous BRAM FIFO.
- Pops one byte at a time from the FIFO read port and serializes it as an 8N1 UART frame on a single tx line, LSB first.
- Absorbs the FIFO's one-cycle registered read latency with an explicit fetch/load sequence.
- Provides busy, done-pulse and frame-count status for software/debug.

---
 rtl/fifo_uart_tx.sv | 194 +++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drain stage for a synchronous BRAM FIFO. Pops one word at a time and
// serializes it LSB first as a UART frame (start, DATA_WIDTH data bits, stop) on tx.
// The FIFO's one-cycle registered read latency is absorbed by a FETCH/LOAD sequence.
//
// Optional feature: define TX_PARITY_EN to insert an even-parity bit between the data
// bits and the stop bit.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   en         permit starting new frames; a frame in progress always completes
//   fifo_empty FIFO empty flag
//   fifo_dout  FIFO read data, valid the cycle after a sampled read
//   fifo_rd_en one-cycle FIFO pop strobe
//   tx         serial line, idle high
//   busy       high whenever not idle
//   tx_done    one-cycle pulse in the last cycle of the stop bit
//   tx_count   frames completed since reset, wrapping
module fifo_uart_tx #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done,
   output logic [CNT_WIDTH-1:0]  tx_count
);

   localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BitW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLoad,
      StStart,
      StData,
`ifdef TX_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   state_e                state_q, state_d;
   logic [BaudW-1:0]      baud_q, baud_d;
   logic [BitW-1:0]       bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  tx_q, tx_d;
   logic                  rd_q, rd_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
`ifdef TX_PARITY_EN
   logic                  par_q, par_d;
`endif

   logic baud_end;
   assign baud_end = (baud_q == BaudLast);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      count_d = count_q;
`ifdef TX_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (en && !fifo_empty) state_d = StFetch;
         end
         StFetch: begin
            state_d = StLoad;
         end
         StLoad: begin
            // Read data from the FETCH pop is valid now.
            shift_d = fifo_dout;
`ifdef TX_PARITY_EN
            par_d   = ^fifo_dout;
`endif
            baud_d  = '0;
            state_d = StStart;
         end
         StStart: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = StData;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StData: begin
            if (baud_end) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BitLast) begin
`ifdef TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
`ifdef TX_PARITY_EN
         StParity: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = StStop;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
`endif
         StStop: begin
            if (baud_end) begin
               baud_d  = '0;
               count_d = count_q + 1'b1;
               state_d = (en && !fifo_empty) ? StFetch : StIdle;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are registered from the next-state values so they line up with the state.
   always_comb begin
      rd_d   = (state_d == StFetch);
      busy_d = (state_d != StIdle);
      done_d = (state_d == StStop) && (baud_d == BaudLast);
      case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
`ifdef TX_PARITY_EN
         StParity: tx_d = par_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         count_q <= '0;
         tx_q    <= 1'b1;
         rd_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         count_q <= count_d;
         tx_q    <= tx_d;
         rd_q    <= rd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign fifo_rd_en = rd_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign tx_done    = done_q;
   assign tx_count   = count_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx: FIFO model with one-cycle read latency, a UART receiver
// that samples mid-bit, and a scoreboard of pushed bytes.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

   localparam int unsigned DW  = 8;
   localparam int unsigned CPB = 4;
   localparam int unsigned CW  = 16;
`ifdef TX_PARITY_EN
   localparam int FrameBits = DW + 3;
`else
   localparam int FrameBits = DW + 2;
`endif
   localparam int FrameCycles = FrameBits * CPB;
   localparam int FetchToStart = 2;
   localparam int B2bGap = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_dout = '0;
   logic          fifo_rd_en;
   logic          tx;
   logic          busy;
   logic          tx_done;
   logic [CW-1:0] tx_count;

   int checks = 0;
   int passed = 0;

   logic [DW-1:0] fifo_q[$];
   int cyc = 0;
   int rd_cnt = 0;
   int rd_cyc = 0;
   int rd_long = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int underflow = 0;
   logic prev_rd = 1'b0;

   fifo_uart_tx #(
      .DATA_WIDTH  (DW),
      .CLKS_PER_BIT(CPB),
      .CNT_WIDTH   (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .fifo_empty(fifo_empty),
      .fifo_dout (fifo_dout),
      .fifo_rd_en(fifo_rd_en),
      .tx        (tx),
      .busy      (busy),
      .tx_done   (tx_done),
      .tx_count  (tx_count)
   );

   always #5 clk = ~clk;

   // FIFO model: registered read data, empty flag updated after the edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fifo_rd_en) begin
         if (fifo_empty) underflow++;
         else fifo_dout <= fifo_q.pop_front();
      end
      fifo_empty <= (fifo_q.size() == 0);
   end

   always @(negedge clk) begin
      if (fifo_rd_en) begin
         rd_cnt++;
         rd_cyc = cyc;
         if (prev_rd) rd_long++;
      end
      prev_rd = fifo_rd_en;
      if (tx_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b0;
      en = 1'b0;
      fifo_q.delete();
      rd_cnt = 0;
      rd_long = 0;
      done_cnt = 0;
      underflow = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic push(input logic [DW-1:0] b);
      fifo_q.push_back(b);
   endtask

   // UART receiver: finds the start edge, then samples each bit in its middle.
   task automatic recv(output logic [DW-1:0] data, output logic start_ok, output logic stop_ok,
                       output logic par, output int start_cyc, output logic timed_out);
      int n;
      n = 0;
      data = '0;
      start_ok = 1'b0;
      stop_ok = 1'b0;
      par = 1'b0;
      start_cyc = 0;
      timed_out = 1'b1;
      while (n < 400) begin
         @(negedge clk);
         n++;
         if (tx === 1'b0) begin
            timed_out = 1'b0;
            break;
         end
      end
      if (timed_out) return;
      start_cyc = cyc;
      repeat (CPB / 2) @(negedge clk);
      start_ok = (tx === 1'b0);
      for (int i = 0; i < DW; i++) begin
         repeat (CPB) @(negedge clk);
         data[i] = tx;
      end
`ifdef TX_PARITY_EN
      repeat (CPB) @(negedge clk);
      par = tx;
`endif
      repeat (CPB) @(negedge clk);
      stop_ok = (tx === 1'b1);
   endtask

   task automatic test_reset();
      @(negedge clk);
      #2;
      rst = 1'b0;
      push(8'h3C);
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (tx !== 1'b1) $display("FAIL reset_tx: got %b required 1", tx);
         else passed++;
         checks++;
         if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b required 0", fifo_rd_en);
         else passed++;
         checks++;
         if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy);
         else passed++;
         checks++;
         if (tx_count !== '0) $display("FAIL reset_count: got %0d required 0", tx_count);
         else passed++;
         checks++;
         if (tx_done !== 1'b0) $display("FAIL reset_done: got %b required 0", tx_done);
         else passed++;
      end
      fifo_q.delete();
      en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_single();
      logic [DW-1:0] d;
      logic so, po, p, to;
      int sc;
      do_reset();
      push(8'hA5);
      en = 1'b1;
      recv(d, so, po, p, sc, to);
      checks++;
      if (to !== 1'b0) $display("FAIL single_timeout: got no start bit required start bit");
      else passed++;
      checks++;
      if (d !== 8'hA5) $display("FAIL single_data: got %02h required a5", d);
      else passed++;
      checks++;
      if (!(so === 1'b1 && po === 1'b1))
         $display("FAIL single_framing: got start_ok=%b stop_ok=%b required 1 1", so, po);
      else passed++;
      checks++;
      if (sc - rd_cyc != FetchToStart)
         $display("FAIL single_latency: got %0d required %0d", sc - rd_cyc, FetchToStart);
      else passed++;
`ifdef TX_PARITY_EN
      checks++;
      if (p !== ^d) $display("FAIL single_parity: got %b required %b", p, ^d);
      else passed++;
`endif
      repeat (CPB) @(negedge clk);
      checks++;
      if (done_cyc - sc + 1 != FrameCycles)
         $display("FAIL single_done_cycle: got %0d required %0d", done_cyc - sc + 1, FrameCycles);
      else passed++;
      checks++;
      if (done_cnt != 1) $display("FAIL single_done_count: got %0d required 1", done_cnt);
      else passed++;
      checks++;
      if (tx_count !== 16'd1) $display("FAIL single_tx_count: got %0d required 1", tx_count);
      else passed++;
      checks++;
      if (rd_cnt != 1 || rd_long != 0)
         $display("FAIL single_pop: got pops=%0d long=%0d required 1 0", rd_cnt, rd_long);
      else passed++;
      checks++;
      if (busy !== 1'b0 || tx !== 1'b1)
         $display("FAIL single_idle: got busy=%b tx=%b required 0 1", busy, tx);
      else passed++;
      en = 1'b0;
   endtask

   // Pushes the given bytes, receives them back to back and checks data, gaps and totals.
   task automatic run_stream(input string name, input logic [DW-1:0] bytes[$]);
      logic [DW-1:0] d;
      logic so, po, p, to;
      int sc;
      logic [DW-1:0] exp_q[$];
      int n;
      n = bytes.size();
      do_reset();
      foreach (bytes[i]) begin
         push(bytes[i]);
         exp_q.push_back(bytes[i]);
      end
      en = 1'b1;
      for (int k = 0; k < n; k++) begin
         logic [DW-1:0] e;
         e = exp_q.pop_front();
         recv(d, so, po, p, sc, to);
         checks++;
         if (to !== 1'b0 || d !== e || so !== 1'b1 || po !== 1'b1)
            $display("FAIL %s_frame%0d: got data=%02h start=%b stop=%b timeout=%b required %02h 1 1 0",
                     name, k, d, so, po, to, e);
         else passed++;
`ifdef TX_PARITY_EN
         checks++;
         if (p !== ^e) $display("FAIL %s_parity%0d: got %b required %b", name, k, p, ^e);
         else passed++;
`endif
         if (k > 0) begin
            checks++;
            if (sc - done_cyc - 1 != B2bGap)
               $display("FAIL %s_gap%0d: got %0d required %0d", name, k, sc - done_cyc - 1, B2bGap);
            else passed++;
         end
      end
      repeat (CPB + 4) @(negedge clk);
      checks++;
      if (tx_count !== CW'(n)) $display("FAIL %s_tx_count: got %0d required %0d", name, tx_count, n);
      else passed++;
      checks++;
      if (rd_cnt != n || rd_long != 0 || underflow != 0)
         $display("FAIL %s_pops: got pops=%0d long=%0d underflow=%0d required %0d 0 0",
                  name, rd_cnt, rd_long, underflow, n);
      else passed++;
      checks++;
      if (busy !== 1'b0 || done_cnt != n)
         $display("FAIL %s_end: got busy=%b done=%0d required 0 %0d", name, busy, done_cnt, n);
      else passed++;
      en = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] b[$];
      b = '{8'h01, 8'h02, 8'h03};
      run_stream("b2b", b);
   endtask

   task automatic test_random();
      logic [DW-1:0] b[$];
      for (int r = 0; r < 2; r++) begin
         int n;
         b.delete();
         n = $urandom_range(3, 6);
         for (int i = 0; i < n; i++) b.push_back(DW'($urandom));
         run_stream("rand", b);
      end
   endtask

   task automatic test_gating();
      logic [DW-1:0] d;
      logic so, po, p, to;
      int sc;
      int lows;
      do_reset();
      en = 1'b1;
      lows = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      checks++;
      if (rd_cnt != 0 || busy !== 1'b0 || lows != 0)
         $display("FAIL gate_empty: got pops=%0d busy=%b lows=%0d required 0 0 0", rd_cnt, busy, lows);
      else passed++;
      en = 1'b0;
      push(8'h5A);
      push(8'h33);
      repeat (20) @(negedge clk);
      checks++;
      if (rd_cnt != 0 || busy !== 1'b0)
         $display("FAIL gate_en_low: got pops=%0d busy=%b required 0 0", rd_cnt, busy);
      else passed++;
      en = 1'b1;
      fork
         begin
            repeat (20) @(negedge clk);
            en = 1'b0;
         end
      join_none
      recv(d, so, po, p, sc, to);
      repeat (CPB + 20) @(negedge clk);
      checks++;
      if (to !== 1'b0 || d !== 8'h5A || po !== 1'b1)
         $display("FAIL gate_frame: got data=%02h stop=%b timeout=%b required 5a 1 0", d, po, to);
      else passed++;
      checks++;
      if (rd_cnt != 1 || busy !== 1'b0 || fifo_q.size() != 1)
         $display("FAIL gate_stop: got pops=%0d busy=%b left=%0d required 1 0 1",
                  rd_cnt, busy, fifo_q.size());
      else passed++;
      checks++;
      if (tx_count !== 16'd1) $display("FAIL gate_tx_count: got %0d required 1", tx_count);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int n;
      int lows;
      logic found;
      do_reset();
      push(8'hFF);
      en = 1'b1;
      found = 1'b0;
      n = 0;
      while (n < 200 && !found) begin
         @(negedge clk);
         n++;
         if (tx === 1'b0) found = 1'b1;
      end
      checks++;
      if (!found) $display("FAIL rstmid_start: got no start bit required start bit");
      else passed++;
      // Move into the middle of data bit 3.
      repeat (CPB + 3 * CPB + 1) @(negedge clk);
      checks++;
      if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b required 1", busy);
      else passed++;
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || tx_done !== 1'b0)
         $display("FAIL rstmid_async: got tx=%b busy=%b rd=%b done=%b required 1 0 0 0",
                  tx, busy, fifo_rd_en, tx_done);
      else passed++;
      checks++;
      if (tx_count !== '0) $display("FAIL rstmid_count: got %0d required 0", tx_count);
      else passed++;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      lows = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      checks++;
      if (lows != 0 || busy !== 1'b0 || rd_cnt != 1 || tx_count !== '0)
         $display("FAIL rstmid_after: got lows=%0d busy=%b pops=%0d count=%0d required 0 0 1 0",
                  lows, busy, rd_cnt, tx_count);
      else passed++;
      en = 1'b0;
   endtask

`ifdef TX_PARITY_EN
   task automatic test_parity();
      logic [DW-1:0] d0, d1;
      logic so, po, p0, p1, to;
      int sc0, sc1;
      do_reset();
      push(8'h07);
      push(8'h03);
      en = 1'b1;
      recv(d0, so, po, p0, sc0, to);
      recv(d1, so, po, p1, sc1, to);
      checks++;
      if (d0 !== 8'h07 || p0 !== 1'b1)
         $display("FAIL parity_07: got data=%02h par=%b required 07 1", d0, p0);
      else passed++;
      checks++;
      if (d1 !== 8'h03 || p1 !== 1'b0)
         $display("FAIL parity_03: got data=%02h par=%b required 03 0", d1, p1);
      else passed++;
      checks++;
      if (sc1 - sc0 - B2bGap != 44)
         $display("FAIL parity_frame_len: got %0d required 44", sc1 - sc0 - B2bGap);
      else passed++;
      repeat (CPB + 4) @(negedge clk);
      en = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_random();
      test_gating();
      test_reset_mid();
`ifdef TX_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
